// File: rtl/fec_dec_sched.sv
// Round-robin scheduler that shares one FEC block decoder among NREQ requesters.
// Optional watchdog with post-timeout FLUSH enabled by defining FEC_SCHED_WDT_EN.
module fec_dec_sched #(
  parameter  int NREQ      = 2,
  parameter  int WIDTH     = 4,
  parameter  int DEPTH     = 4,
  parameter  int TO_CYCLES = 32,
  localparam int IDW       = (NREQ > 1) ? $clog2(NREQ) : 1,
  localparam int BW        = WIDTH * DEPTH
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NREQ-1:0]                req_valid_i,
  output logic [NREQ-1:0]                req_ready_o,
  input  logic [NREQ-1:0][BW-1:0]        req_data_i,
  input  logic [NREQ-1:0][DEPTH-1:0]     req_rowp_i,
  input  logic [NREQ-1:0][WIDTH-1:0]     req_colp_i,
  output logic                           dec_start_o,
  output logic [BW-1:0]                  dec_data_o,
  output logic [DEPTH-1:0]               dec_rowp_o,
  output logic [WIDTH-1:0]               dec_colp_o,
  input  logic                           dec_done_i,
  input  logic                           dec_err_det_i,
  input  logic                           dec_err_cor_i,
  input  logic [BW-1:0]                  dec_data_corr_i,
  output logic                           rsp_valid_o,
  input  logic                           rsp_ready_i,
  output logic [IDW-1:0]                 rsp_id_o,
  output logic [BW-1:0]                  rsp_data_o,
  output logic                           rsp_err_det_o,
  output logic                           rsp_err_cor_o,
  output logic                           rsp_timeout_o,
  output logic [15:0]                    cnt_corr_o,
  output logic [15:0]                    cnt_uncorr_o
);

  typedef enum logic [2:0] {IDLE, LAUNCH, WAIT, RESP, FLUSH} state_e;
  state_e state_q, state_d;

  logic [IDW-1:0]   last_grant_q, gnt_idx, k;
  logic             gnt_vld;
  logic [BW-1:0]    op_data_q, rsp_data_q;
  logic [DEPTH-1:0] op_rowp_q;
  logic [WIDTH-1:0] op_colp_q;
  logic [IDW-1:0]   rsp_id_q;
  logic             rsp_det_q, rsp_cor_q;
  logic [15:0]      cnt_corr_q, cnt_uncorr_q;
  logic             accept;

`ifdef FEC_SCHED_WDT_EN
  localparam int WDW = $clog2(TO_CYCLES + 1);
  localparam logic [WDW-1:0] WDT_LAST = WDW'(TO_CYCLES - 1);
  logic [WDW-1:0] wdt_q, wdt_d;
  logic           rsp_to_q;
  assign rsp_timeout_o = rsp_to_q;
`else
  assign rsp_timeout_o = 1'b0;
`endif

  // Descending scan so the last hit is the nearest requester after last_grant.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    k       = '0;
    for (int i = NREQ; i >= 1; i--) begin
      k = IDW'((int'(last_grant_q) + i) % NREQ);
      if (req_valid_i[k]) begin
        gnt_vld = 1'b1;
        gnt_idx = k;
      end
    end
  end

  always_comb begin
    req_ready_o = '0;
    if (rst_n && state_q == IDLE && gnt_vld) req_ready_o[gnt_idx] = 1'b1;
  end

  assign accept = (state_q == RESP) && rsp_ready_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    dec_start_o = 1'b0;
    rsp_valid_o = 1'b0;
`ifdef FEC_SCHED_WDT_EN
    wdt_d       = '0;
`endif
    case (state_q)
      IDLE:   if (gnt_vld) state_d = LAUNCH;
      LAUNCH: begin
        dec_start_o = 1'b1;
        state_d     = WAIT;
      end
      WAIT: begin
        if (dec_done_i) state_d = RESP;
`ifdef FEC_SCHED_WDT_EN
        else if (wdt_q == WDT_LAST) state_d = RESP;
        else wdt_d = wdt_q + 1'b1;
`endif
      end
      RESP: begin
        rsp_valid_o = 1'b1;
`ifdef FEC_SCHED_WDT_EN
        if (rsp_ready_i) state_d = rsp_to_q ? FLUSH : IDLE;
`else
        if (rsp_ready_i) state_d = IDLE;
`endif
      end
      FLUSH: begin
`ifdef FEC_SCHED_WDT_EN
        // Swallow the late done of the abandoned block before re-arbitrating.
        if (dec_done_i || wdt_q == WDT_LAST) state_d = IDLE;
        else wdt_d = wdt_q + 1'b1;
`else
        state_d = IDLE;
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant_q <= IDW'(NREQ - 1);
      op_data_q    <= '0;
      op_rowp_q    <= '0;
      op_colp_q    <= '0;
      rsp_id_q     <= '0;
      rsp_data_q   <= '0;
      rsp_det_q    <= 1'b0;
      rsp_cor_q    <= 1'b0;
      cnt_corr_q   <= '0;
      cnt_uncorr_q <= '0;
`ifdef FEC_SCHED_WDT_EN
      wdt_q        <= '0;
      rsp_to_q     <= 1'b0;
`endif
    end else begin
`ifdef FEC_SCHED_WDT_EN
      wdt_q <= wdt_d;
`endif
      if (state_q == IDLE && gnt_vld) begin
        op_data_q    <= req_data_i[gnt_idx];
        op_rowp_q    <= req_rowp_i[gnt_idx];
        op_colp_q    <= req_colp_i[gnt_idx];
        rsp_id_q     <= gnt_idx;
        last_grant_q <= gnt_idx;
      end
      if (state_q == WAIT && dec_done_i) begin
        rsp_data_q <= dec_data_corr_i;
        rsp_det_q  <= dec_err_det_i;
        rsp_cor_q  <= dec_err_cor_i;
`ifdef FEC_SCHED_WDT_EN
        rsp_to_q   <= 1'b0;
      end else if (state_q == WAIT && wdt_q == WDT_LAST) begin
        rsp_data_q <= op_data_q;
        rsp_det_q  <= 1'b1;
        rsp_cor_q  <= 1'b0;
        rsp_to_q   <= 1'b1;
`endif
      end
      if (accept) begin
        if (rsp_det_q && rsp_cor_q && cnt_corr_q != 16'hFFFF)
          cnt_corr_q <= cnt_corr_q + 16'd1;
        if (((rsp_det_q && !rsp_cor_q) || rsp_timeout_o) && cnt_uncorr_q != 16'hFFFF)
          cnt_uncorr_q <= cnt_uncorr_q + 16'd1;
      end
    end
  end

  assign dec_data_o    = op_data_q;
  assign dec_rowp_o    = op_rowp_q;
  assign dec_colp_o    = op_colp_q;
  assign rsp_id_o      = rsp_id_q;
  assign rsp_data_o    = rsp_data_q;
  assign rsp_err_det_o = rsp_det_q;
  assign rsp_err_cor_o = rsp_cor_q;
  assign cnt_corr_o    = cnt_corr_q;
  assign cnt_uncorr_o  = cnt_uncorr_q;

endmodule

// File: tb/tb_fec_dec_sched.sv
// Directed bench for fec_dec_sched: arbitration, decoder handshake, counters, reset abort.
// The watchdog scenario is compiled in only when FEC_SCHED_WDT_EN is defined.
module tb_fec_dec_sched;
  localparam int NREQ = 2, WIDTH = 4, DEPTH = 4, TO_CYCLES = 32, IDW = 1, BW = 16;
  localparam int OPW = BW + DEPTH + WIDTH;

  logic clk = 1'b0, rst_n = 1'b0;
  logic [NREQ-1:0] req_valid = '0, req_ready;
  logic [NREQ-1:0][BW-1:0] req_data;
  logic [NREQ-1:0][DEPTH-1:0] req_rowp;
  logic [NREQ-1:0][WIDTH-1:0] req_colp;
  logic dec_start, dec_done = 1'b0, dec_err_det = 1'b0, dec_err_cor = 1'b0;
  logic [BW-1:0] dec_data, dec_data_corr = '0, rsp_data;
  logic [DEPTH-1:0] dec_rowp;
  logic [WIDTH-1:0] dec_colp;
  logic rsp_valid, rsp_ready = 1'b0, rsp_err_det, rsp_err_cor, rsp_timeout;
  logic [IDW-1:0] rsp_id;
  logic [15:0] cnt_corr, cnt_uncorr;
  int total = 0, bad = 0, cyc = 0;

  localparam logic [BW-1:0] D0 = 16'hA5C3, D1 = 16'h3C96;
  localparam logic [DEPTH-1:0] R0 = 4'h9, R1 = 4'h3;
  localparam logic [WIDTH-1:0] C0 = 4'h6, C1 = 4'hC;

  fec_dec_sched #(.NREQ(NREQ), .WIDTH(WIDTH), .DEPTH(DEPTH), .TO_CYCLES(TO_CYCLES)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_data_i(req_data),
    .req_rowp_i(req_rowp), .req_colp_i(req_colp),
    .dec_start_o(dec_start), .dec_data_o(dec_data), .dec_rowp_o(dec_rowp), .dec_colp_o(dec_colp),
    .dec_done_i(dec_done), .dec_err_det_i(dec_err_det), .dec_err_cor_i(dec_err_cor),
    .dec_data_corr_i(dec_data_corr),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_id_o(rsp_id), .rsp_data_o(rsp_data),
    .rsp_err_det_o(rsp_err_det), .rsp_err_cor_o(rsp_err_cor), .rsp_timeout_o(rsp_timeout),
    .cnt_corr_o(cnt_corr), .cnt_uncorr_o(cnt_uncorr));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #300000;
    $display("FAIL global_timeout: simulation did not finish, required finish before 300000");
    $fatal(1);
  end

  // Inputs change 1 time unit after the rising edge; outputs are sampled 1 unit later.
  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0; req_valid = '0; dec_done = 1'b0; rsp_ready = 1'b0;
    step(); step();
    rst_n = 1'b1;
  endtask

  // Plays requester/decoder/consumer for one block; returns observations for the caller to judge.
  task automatic serve(input int lat, input logic [BW-1:0] corr, input logic det, input logic cor,
                       input int hold, input bit drop,
                       output logic [NREQ-1:0] gnt, output int t_acc, output int t_start,
                       output int t_done, output int t_rsp, output int t_fin,
                       output logic [IDW-1:0] id, output logic [OPW-1:0] ops, output logic [BW-1:0] rd,
                       output logic rdet, output logic rcor, output logic rto,
                       output bit stable, output bit anom, output bit lost);
    gnt = '0; t_acc = -1; t_start = -1; t_done = -1; t_rsp = -1; t_fin = -1;
    id = '0; ops = '0; rd = '0; rdet = 1'b0; rcor = 1'b0; rto = 1'b0;
    stable = 1'b1; anom = 1'b0; lost = 1'b0;
    for (int n = 0; n < 60 && gnt == '0; n++) begin
      #1; if (req_ready != '0) begin gnt = req_ready; t_acc = cyc; end
      step();
    end
    if (gnt == '0) begin lost = 1'b1; return; end
    if (drop) req_valid = req_valid & ~gnt;
    for (int n = 0; n < 10 && t_start < 0; n++) begin
      #1; if (dec_start) begin t_start = cyc; ops = {dec_colp, dec_rowp, dec_data}; end
      step();
    end
    if (t_start < 0) begin lost = 1'b1; return; end
    if (lat > 0) begin
      for (int n = 1; n < lat; n++) begin
        #1;
        if (req_ready != '0 || rsp_valid || dec_start || {dec_colp, dec_rowp, dec_data} !== ops) anom = 1'b1;
        step();
      end
      dec_done = 1'b1; dec_data_corr = corr; dec_err_det = det; dec_err_cor = cor; t_done = cyc;
      #1;
      if (req_ready != '0 || rsp_valid || {dec_colp, dec_rowp, dec_data} !== ops) anom = 1'b1;
      step();
      dec_done = 1'b0;
    end
    for (int n = 0; n < 50 && t_rsp < 0; n++) begin
      #1;
      if (rsp_valid) begin
        t_rsp = cyc; id = rsp_id; rd = rsp_data; rdet = rsp_err_det; rcor = rsp_err_cor; rto = rsp_timeout;
      end else step();
    end
    if (t_rsp < 0) begin lost = 1'b1; return; end
    for (int h = 0; h < hold; h++) begin
      step(); #1;
      if (!rsp_valid || rsp_id !== id || rsp_data !== rd || rsp_err_det !== rdet ||
          rsp_err_cor !== rcor || rsp_timeout !== rto) stable = 1'b0;
    end
    rsp_ready = 1'b1; t_fin = cyc;
    #1; if (!rsp_valid || req_ready != '0) anom = 1'b1;
    step();
    rsp_ready = 1'b0;
  endtask

  logic [NREQ-1:0] g; int ta, ts, td, tr, tf; logic [IDW-1:0] id;
  logic [OPW-1:0] ops; logic [BW-1:0] rd; logic rdet, rcor, rto; bit stb, anm, lst;

  task automatic test_reset();
    rst_n = 1'b0; req_valid = 2'b11;
    step(); #1;
    total++; if (req_ready !== 2'b00) begin bad++; $display("FAIL rst_ready: got %b want 00", req_ready); end
    total++; if ({dec_start, rsp_valid, rsp_err_det, rsp_err_cor, rsp_timeout} !== 5'b0) begin bad++;
      $display("FAIL rst_flags: got %b want 00000", {dec_start, rsp_valid, rsp_err_det, rsp_err_cor, rsp_timeout}); end
    total++; if ({rsp_id, rsp_data, dec_data, dec_rowp, dec_colp} !== '0) begin bad++;
      $display("FAIL rst_data: got %h want 0", {rsp_id, rsp_data, dec_data, dec_rowp, dec_colp}); end
    total++; if ({cnt_corr, cnt_uncorr} !== 32'h0) begin bad++;
      $display("FAIL rst_cnt: got %h want 0", {cnt_corr, cnt_uncorr}); end
    req_valid = '0; step(); rst_n = 1'b1; step();
    // A stray done while idle must not produce a response.
    dec_done = 1'b1; dec_err_det = 1'b1; step(); dec_done = 1'b0; dec_err_det = 1'b0; #1;
    total++; if (rsp_valid !== 1'b0 || cnt_uncorr !== 16'h0) begin bad++;
      $display("FAIL idle_done_ignored: got valid=%b cnt=%0d want 0 0", rsp_valid, cnt_uncorr); end
    step();
  endtask

  task automatic test_basic();
    req_valid = 2'b01;
    serve(3, D0, 1'b0, 1'b0, 0, 1'b1, g, ta, ts, td, tr, tf, id, ops, rd, rdet, rcor, rto, stb, anm, lst);
    total++; if (lst || g !== 2'b01) begin bad++; $display("FAIL basic_grant: got %b lost=%0d want 01", g, lst); end
    total++; if (ts !== ta + 1) begin bad++; $display("FAIL basic_start_lat: got %0d want %0d", ts - ta, 1); end
    total++; if (tr !== td + 1) begin bad++; $display("FAIL basic_rsp_lat: got %0d want %0d", tr - td, 1); end
    total++; if (ops !== {C0, R0, D0}) begin bad++; $display("FAIL basic_ops: got %h want %h", ops, {C0, R0, D0}); end
    total++; if (id !== 1'b0 || rd !== D0 || {rdet, rcor, rto} !== 3'b000) begin bad++;
      $display("FAIL basic_rsp: got id=%0d data=%h st=%b want 0 %h 000", id, rd, {rdet, rcor, rto}, D0); end
    total++; if (anm) begin bad++; $display("FAIL basic_anomaly: got 1 want 0"); end
    total++; if ({cnt_corr, cnt_uncorr} !== 32'h0) begin bad++;
      $display("FAIL basic_cnt: got %h want 0", {cnt_corr, cnt_uncorr}); end
  endtask

  task automatic test_back_to_back();
    logic [NREQ-1:0] eg [3];
    logic [BW-1:0] corr;
    int prev_fin;
    eg[0] = 2'b01; eg[1] = 2'b10; eg[2] = 2'b01;
    apply_reset();
    req_valid = 2'b11; prev_fin = -1;
    for (int n = 0; n < 3; n++) begin
      corr = 16'h1111 * 16'(n + 1);
      serve(2, corr, 1'b0, 1'b0, 0, 1'b0, g, ta, ts, td, tr, tf, id, ops, rd, rdet, rcor, rto, stb, anm, lst);
      total++; if (lst || g !== eg[n] || !$onehot(g)) begin bad++;
        $display("FAIL b2b_grant%0d: got %b want %b", n, g, eg[n]); end
      total++; if (id !== IDW'(n % 2) || rd !== corr) begin bad++;
        $display("FAIL b2b_rsp%0d: got id=%0d data=%h want %0d %h", n, id, rd, n % 2, corr); end
      total++; if (ops !== ((n % 2 == 0) ? {C0, R0, D0} : {C1, R1, D1})) begin bad++;
        $display("FAIL b2b_ops%0d: got %h", n, ops); end
      total++; if (anm) begin bad++; $display("FAIL b2b_anomaly%0d: got 1 want 0", n); end
      if (n > 0) begin
        total++; if (ta !== prev_fin + 1) begin bad++;
          $display("FAIL b2b_regrant%0d: got %0d want %0d", n, ta - prev_fin, 1); end
      end
      prev_fin = tf;
    end
    req_valid = '0;
    step();
  endtask

  task automatic test_corrected();
    logic [BW-1:0] flip;
    flip = D0 ^ 16'h0200;
    req_valid = 2'b01;
    serve(3, flip, 1'b1, 1'b1, 5, 1'b1, g, ta, ts, td, tr, tf, id, ops, rd, rdet, rcor, rto, stb, anm, lst);
    total++; if (lst || rd !== flip || {rdet, rcor, rto} !== 3'b110) begin bad++;
      $display("FAIL corr_rsp: got data=%h st=%b want %h 110", rd, {rdet, rcor, rto}, flip); end
    total++; if (!stb || tf !== tr + 5) begin bad++;
      $display("FAIL corr_stable: got stable=%0d cycles=%0d want 1 6", stb, tf - tr + 1); end
    total++; if (cnt_corr !== 16'd1 || cnt_uncorr !== 16'd0) begin bad++;
      $display("FAIL corr_cnt: got %0d/%0d want 1/0", cnt_corr, cnt_uncorr); end
    req_valid = 2'b01;
    serve(4, D0, 1'b1, 1'b0, 0, 1'b1, g, ta, ts, td, tr, tf, id, ops, rd, rdet, rcor, rto, stb, anm, lst);
    total++; if (lst || cnt_corr !== 16'd1 || cnt_uncorr !== 16'd1) begin bad++;
      $display("FAIL uncorr_cnt: got %0d/%0d want 1/1", cnt_corr, cnt_uncorr); end
  endtask

`ifdef FEC_SCHED_WDT_EN
  task automatic test_watchdog();
    int t_idle;
    req_valid = 2'b01;
    serve(0, '0, 1'b0, 1'b0, 0, 1'b1, g, ta, ts, td, tr, tf, id, ops, rd, rdet, rcor, rto, stb, anm, lst);
    total++; if (lst || tr !== ts + 1 + TO_CYCLES) begin bad++;
      $display("FAIL wdt_latency: got %0d want %0d", tr - ts - 1, TO_CYCLES); end
    total++; if (rd !== D0 || {rdet, rcor, rto} !== 3'b101) begin bad++;
      $display("FAIL wdt_rsp: got data=%h st=%b want %h 101", rd, {rdet, rcor, rto}, D0); end
    total++; if (cnt_uncorr !== 16'd2) begin bad++; $display("FAIL wdt_cnt: got %0d want 2", cnt_uncorr); end
    req_valid = 2'b01; t_idle = -1;
    for (int n = 0; n < 60 && t_idle < 0; n++) begin
      #1; if (req_ready != '0) t_idle = cyc; else step();
    end
    total++; if (t_idle !== tf + 1 + TO_CYCLES) begin bad++;
      $display("FAIL wdt_flush: got %0d want %0d", t_idle - tf - 1, TO_CYCLES); end
    step();
    req_valid = '0;
    serve(2, D0, 1'b0, 1'b0, 0, 1'b1, g, ta, ts, td, tr, tf, id, ops, rd, rdet, rcor, rto, stb, anm, lst);
  endtask
`else
  task automatic test_no_watchdog();
    req_valid = 2'b10;
    serve(45, D1, 1'b0, 1'b0, 0, 1'b1, g, ta, ts, td, tr, tf, id, ops, rd, rdet, rcor, rto, stb, anm, lst);
    total++; if (lst || anm || tr !== td + 1) begin bad++;
      $display("FAIL nowdt_wait: got lost=%0d early=%0d lat=%0d want 0 0 1", lst, anm, tr - td); end
    total++; if (id !== 1'b1 || rd !== D1 || rto !== 1'b0) begin bad++;
      $display("FAIL nowdt_rsp: got id=%0d data=%h to=%b want 1 %h 0", id, rd, rto, D1); end
  endtask
`endif

  task automatic test_reset_wait();
    bit seen;
    req_valid = 2'b01;
    for (int n = 0; n < 20 && req_ready == '0; n++) begin #1; if (req_ready == '0) step(); end
    step();
    req_valid = 2'b11;
    step(); step();
    rst_n = 1'b0; #1;
    total++; if ({req_ready, dec_start, rsp_valid, rsp_err_det, rsp_err_cor, rsp_timeout} !== '0) begin bad++;
      $display("FAIL rstw_flags: got %b want 0", {req_ready, dec_start, rsp_valid, rsp_err_det, rsp_err_cor, rsp_timeout}); end
    total++; if ({rsp_id, rsp_data, dec_data, dec_rowp, dec_colp, cnt_corr, cnt_uncorr} !== '0) begin bad++;
      $display("FAIL rstw_data: got %h want 0", {rsp_id, rsp_data, dec_data, dec_rowp, dec_colp, cnt_corr, cnt_uncorr}); end
    seen = 1'b0;
    for (int n = 0; n < 3; n++) begin step(); #1; if (rsp_valid) seen = 1'b1; end
    step();
    rst_n = 1'b1; #1;
    total++; if (seen || req_ready !== 2'b01) begin bad++;
      $display("FAIL rstw_regrant: got ready=%b rsp=%0d want 01 0", req_ready, seen); end
    serve(2, D0, 1'b0, 1'b0, 0, 1'b1, g, ta, ts, td, tr, tf, id, ops, rd, rdet, rcor, rto, stb, anm, lst);
    total++; if (lst || g !== 2'b01 || rd !== D0) begin bad++;
      $display("FAIL rstw_first: got %b %h want 01 %h", g, rd, D0); end
    serve(2, D1, 1'b0, 1'b0, 0, 1'b1, g, ta, ts, td, tr, tf, id, ops, rd, rdet, rcor, rto, stb, anm, lst);
    total++; if (lst || g !== 2'b10 || ops !== {C1, R1, D1}) begin bad++;
      $display("FAIL rstw_second: got %b %h want 10 %h", g, ops, {C1, R1, D1}); end
    req_valid = '0;
  endtask

  initial begin
    req_data[0] = D0; req_data[1] = D1;
    req_rowp[0] = R0; req_rowp[1] = R1;
    req_colp[0] = C0; req_colp[1] = C1;
    step();
    test_reset();
    test_basic();
    test_back_to_back();
    test_corrected();
`ifdef FEC_SCHED_WDT_EN
    test_watchdog();
`else
    test_no_watchdog();
`endif
    test_reset_wait();
    step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/fec_dec_sched.md
FEC_DEC_SCHED -- requirements
Module: fec_dec_sched

Interface
REQ-001 Parameters SHALL be: NREQ, default 2, number of requesters; WIDTH, default 4, decoder block columns; DEPTH, default 4, decoder block rows; TO_CYCLES, default 32, watchdog limit in clocks.
REQ-002 clk  input  1  clock, all state on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 req_valid  input  NREQ  per-requester block-pending flag.
REQ-005 req_ready  output  NREQ  per-requester accept strobe.
REQ-006 req_data  input  NREQ*WIDTH*DEPTH  flattened per-requester data blocks; requester k occupies slice k.
REQ-007 req_rowp / req_colp  input  NREQ*DEPTH / NREQ*WIDTH  per-requester received row and column parity.
REQ-008 dec_start  output  1  one-cycle start pulse to the shared decoder.
REQ-009 dec_data / dec_rowp / dec_colp  output  WIDTH*DEPTH / DEPTH / WIDTH  operands driven to the decoder.
REQ-010 dec_done, dec_err_det, dec_err_cor  input  1 each  decoder completion pulse and status.
REQ-011 dec_data_corr  input  WIDTH*DEPTH  decoder corrected data.
REQ-012 rsp_valid  output  1  response pending; rsp_ready  input  1  response accept.
REQ-013 rsp_id  output  $clog2(NREQ) (min 1)  requester index; rsp_data  output  WIDTH*DEPTH  result data.
REQ-014 rsp_err_det, rsp_err_cor, rsp_timeout  output  1 each  response status.
REQ-015 cnt_corr, cnt_uncorr  output  16 each  saturating event counters.

Function
REQ-016 FSM SHALL have states IDLE, LAUNCH, WAIT, RESP, FLUSH.
REQ-017 IDLE: if any req_valid, grant round-robin starting from (last_grant+1) mod NREQ; req_ready[g] SHALL be combinationally high in that cycle only; at the edge, capture req_data/rowp/colp of g, update last_grant, go LAUNCH.
REQ-018 req_ready SHALL be all-zero outside IDLE and when no req_valid.
REQ-019 LAUNCH: dec_start=1 for exactly one cycle; next state WAIT.
REQ-020 dec_data/rowp/colp SHALL drive the captured operands, stable from LAUNCH until leaving WAIT.
REQ-021 WAIT: on dec_done, register dec_data_corr, dec_err_det, dec_err_cor into rsp_* with rsp_timeout=0, go RESP.
REQ-022 RESP: rsp_valid=1 with payload held stable until rsp_valid&&rsp_ready, then IDLE; no new grant in the accept cycle.
REQ-023 Minimum latency: accept at cycle N, dec_start at N+1, rsp_valid at D+1, where D is the dec_done cycle.
REQ-024 dec_done outside WAIT/FLUSH SHALL be ignored.
REQ-025 On response accept, cnt_corr+1 if err_det&&err_cor; cnt_uncorr+1 if (err_det&&!err_cor) or timeout. Both counters saturate at 16'hFFFF.
REQ-026 last_grant reset value SHALL be NREQ-1, so requester 0 wins the first arbitration.

Reset
REQ-027 While rst_n=0: state=IDLE; req_ready, dec_start, rsp_valid, rsp_err_det, rsp_err_cor, rsp_timeout = 0; rsp_id, rsp_data, dec_data, dec_rowp, dec_colp = 0; counters = 0.
REQ-028 Reset in any state SHALL abort the operation without emitting a response; a pending request stays pending at its requester.

Configuration
REQ-029 Macro FEC_SCHED_WDT_EN defined: a WAIT cycle counter SHALL reach TO_CYCLES without dec_done, then load rsp_data=captured data, rsp_err_det=1, rsp_err_cor=0, rsp_timeout=1, and go RESP. After that response is accepted, FSM goes to FLUSH. FLUSH exits to IDLE on dec_done or after TO_CYCLES further cycles.
REQ-030 Macro undefined: no watchdog and no FLUSH entry; WAIT waits indefinitely; rsp_timeout is tied to 0.

Verification (NREQ=2, WIDTH=DEPTH=4, TO_CYCLES=32)
REQ-031 Req0 valid, decoder model returns done 3 cycles after start, err_det=0 -> dec_start 1 cycle after accept; rsp_id=0; rsp_data equals model data; both counters stay 0.
REQ-032 Req0 and req1 continuously valid for 3 blocks -> grant order 0,1,0; req_ready one-hot, one pulse per accept.
REQ-033 Model returns err_det=1, err_cor=1 with bit [2][1] flipped; rsp_ready low for 5 cycles -> rsp_valid and payload stable for 6 cycles; cnt_corr=1 after accept.
REQ-034 WDT_EN, dec_done never asserted -> rsp_valid at cycle 32 after WAIT entry, rsp_timeout=1, rsp_data=original, cnt_uncorr=1; FSM reaches IDLE 32 cycles after accept.
REQ-035 rst_n pulsed low during WAIT -> all outputs reach REQ-027 values immediately; no response is emitted; a still-valid request is re-granted to requester 0 after reset release.
